// File: rtl/fb_plot_if.sv
// Pixel plot request channel between the game datapath (master) and the
// framebuffer plot receiver (slave).
interface fb_plot_if;
  logic       plot;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot_ready;

  modport master (output plot, x, y, colour, input plot_ready);
  modport slave  (input plot, x, y, colour, output plot_ready);
endinterface

// File: rtl/fb_plot_receiver.sv
// Plot receiver: buffers plot requests, clips off-screen pixels, converts
// (x,y) to a linear address and drives the framebuffer write port; also clears the screen.
module fb_plot_receiver #(
  parameter int         H_RES        = 160,
  parameter int         V_RES        = 120,
  parameter int         FIFO_DEPTH   = 4,
  parameter int         ADDR_W       = 15,
  parameter logic [2:0] CLEAR_COLOUR = 3'b000
) (
  input  logic              clk,
  input  logic              reset,
  fb_plot_if.slave          req,
  input  logic              clear,
  output logic              busy,
  output logic              clear_done,
  output logic [7:0]        drop_count,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [2:0]        mem_data,
  output logic              mem_we
);

  localparam int                PTR_W     = $clog2(FIFO_DEPTH);
  localparam logic [8:0]        X_LIM     = 9'(H_RES);
  localparam logic [7:0]        Y_LIM     = 8'(V_RES);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);

  typedef enum logic [1:0] {IDLE, DRAIN, CLEAR, DONE} state_t;

  state_t state_reg, state_next;

  logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
  logic [2:0]        fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [PTR_W:0]    count_reg;

  logic              ready_en_reg;
  logic              clear_pending_reg;
  logic [7:0]        drop_count_reg;
  logic [ADDR_W-1:0] clr_cnt_reg;
  logic              stg_valid_reg;
  logic [ADDR_W-1:0] stg_addr_reg;
  logic [2:0]        stg_data_reg;
  logic              mem_we_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic [2:0]        mem_data_reg;
  logic              clear_done_reg;

  logic              fifo_full, fifo_empty;
  logic              accept, clipped, push, pop, clear_wr, clear_take;
  logic [ADDR_W-1:0] push_addr;

  assign fifo_full  = (count_reg == (PTR_W+1)'(FIFO_DEPTH));
  assign fifo_empty = (count_reg == '0);
  assign clipped    = ({1'b0, req.x} >= X_LIM) || ({1'b0, req.y} >= Y_LIM);
  assign accept     = req.plot && req.plot_ready;
  assign push       = accept && !clipped;

  // 160 = 128 + 32, so the default screen needs no multiplier.
  generate
    if (H_RES == 160) begin : g_shift_add
      assign push_addr = (ADDR_W'(req.y) << 7) + (ADDR_W'(req.y) << 5) + ADDR_W'(req.x);
    end else begin : g_mult
      assign push_addr = ADDR_W'(req.y) * ADDR_W'(H_RES) + ADDR_W'(req.x);
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (clear) state_next = DRAIN;
      DRAIN:   if (fifo_empty) state_next = CLEAR;
      CLEAR:   if (clr_cnt_reg == LAST_ADDR) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req.plot_ready = ready_en_reg && !fifo_full && !clear_pending_reg && (state_reg != CLEAR);
    pop            = ((state_reg == IDLE) || (state_reg == DRAIN)) && !fifo_empty;
    clear_wr       = (state_reg == CLEAR);
    clear_take     = (state_reg == IDLE) && clear;
    busy           = !fifo_empty || clear_pending_reg || (state_reg != IDLE)
                     || stg_valid_reg || mem_we_reg;
  end

  // Storage and registered read have no reset so they map onto RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr_reg] <= push_addr;
      fifo_data[wr_ptr_reg] <= req.colour;
    end
    if (pop) begin
      stg_addr_reg <= fifo_addr[rd_ptr_reg];
      stg_data_reg <= fifo_data[rd_ptr_reg];
    end else if (clear_wr) begin
      stg_addr_reg <= clr_cnt_reg;
      stg_data_reg <= CLEAR_COLOUR;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready_en_reg      <= 1'b0;
      wr_ptr_reg        <= '0;
      rd_ptr_reg        <= '0;
      count_reg         <= '0;
      clear_pending_reg <= 1'b0;
      drop_count_reg    <= '0;
      clr_cnt_reg       <= '0;
      stg_valid_reg     <= 1'b0;
      mem_we_reg        <= 1'b0;
      mem_addr_reg      <= '0;
      mem_data_reg      <= '0;
      clear_done_reg    <= 1'b0;
    end else begin
      ready_en_reg <= 1'b1;
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + (PTR_W+1)'(1);
        2'b01:   count_reg <= count_reg - (PTR_W+1)'(1);
        default: count_reg <= count_reg;
      endcase
      if (accept && clipped && (drop_count_reg != 8'hFF))
        drop_count_reg <= drop_count_reg + 8'd1;
      if (clear_take)
        clear_pending_reg <= 1'b1;
      else if (state_reg == DONE)
        clear_pending_reg <= 1'b0;
      if (state_reg == DRAIN)
        clr_cnt_reg <= '0;
      else if (clear_wr)
        clr_cnt_reg <= clr_cnt_reg + ADDR_W'(1);
      // Pop and clear writes share one pipeline, so write order is preserved.
      stg_valid_reg <= pop || clear_wr;
      mem_we_reg    <= stg_valid_reg;
      if (stg_valid_reg) begin
        mem_addr_reg <= stg_addr_reg;
        mem_data_reg <= stg_data_reg;
      end
      clear_done_reg <= (state_reg == DONE);
    end
  end

  assign clear_done = clear_done_reg;
  assign drop_count = drop_count_reg;
  assign mem_addr   = mem_addr_reg;
  assign mem_data   = mem_data_reg;
  assign mem_we     = mem_we_reg;

endmodule

// File: tb/tb_fb_plot_receiver.sv
// Scoreboard bench for fb_plot_receiver: driver pushes expected writes, the
// negedge monitor pops and compares every framebuffer write.
module tb_fb_plot_receiver;
  localparam int H = 160;
  localparam int V = 120;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear;
  logic        busy, clear_done, mem_we;
  logic [7:0]  drop_count;
  logic [14:0] mem_addr;
  logic [2:0]  mem_data;

  fb_plot_if pif ();

  fb_plot_receiver #(.H_RES(H), .V_RES(V), .FIFO_DEPTH(DEPTH), .ADDR_W(15),
                     .CLEAR_COLOUR(3'b000)) dut (
    .clk(clk), .reset(reset), .req(pif), .clear(clear), .busy(busy),
    .clear_done(clear_done), .drop_count(drop_count), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_we(mem_we));

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  logic [17:0] exp_q[$];
  int          exp_drop = 0;
  int          clears_issued = 0;
  int          clears_done = 0;
  bit          done_prev = 1'b0;
  logic [17:0] mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req_v);
    end
  endtask

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("write_expected", 32'd0, 32'd1);
      end else begin
        mon_e = exp_q.pop_front();
        check("write_addr", 32'(mem_addr), 32'(mon_e[17:3]));
        check("write_data", 32'(mem_data), 32'(mon_e[2:0]));
      end
    end
    if (done_prev) check("busy_after_done", 32'(busy), 32'd0);
    done_prev = clear_done;
    if (clear_done === 1'b1) begin
      check("done_expected", 32'((clears_issued != clears_done) && (exp_q.size() == 0)), 32'd1);
      clears_done++;
      $display("clear_done observed");
    end
    if (clears_issued != clears_done) check("ready_low_in_clear", 32'(pif.plot_ready), 32'd0);
  end

  task automatic drive_cycle(input bit p, input int xi, input int yi, input int ci, input bit clr);
    @(negedge clk);
    pif.plot = p; pif.x = 8'(xi); pif.y = 7'(yi); pif.colour = 3'(ci); clear = clr;
    #1;
    if (p && pif.plot_ready) begin
      if (xi >= H || yi >= V) begin
        exp_drop = (exp_drop == 255) ? 255 : exp_drop + 1;
        $display("plot x=%0d y=%0d c=%0d clipped", xi, yi, ci);
      end else begin
        check("fifo_not_overfull", 32'(exp_q.size() <= DEPTH), 32'd1);
        exp_q.push_back({15'(yi * H + xi), 3'(ci)});
        $display("plot x=%0d y=%0d c=%0d accepted addr=%0d", xi, yi, ci, yi * H + xi);
      end
    end
    if (clr && clears_issued == clears_done) begin
      clears_issued++;
      for (int i = 0; i < H * V; i++) exp_q.push_back({15'(i), 3'b000});
      $display("clear accepted");
    end
    @(posedge clk);
  endtask

  task automatic idle_in();
    #1;
    pif.plot = 1'b0;
    clear = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 25000 && !ok; i++) begin
      @(negedge clk);
      #2;
      ok = !busy && (exp_q.size() == 0);
    end
    check({name, "_idle"}, 32'(ok), 32'd1);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    pif.plot = 1'b0;
    clear = 1'b0;
    exp_q.delete();
    exp_drop = 0;
    clears_issued = clears_done;
    #1;
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_data", 32'(mem_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_clear_done", 32'(clear_done), 32'd0);
    check("rst_drop", 32'(drop_count), 32'd0);
    check("rst_ready", 32'(pif.plot_ready), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("ready_before_edge", 32'(pif.plot_ready), 32'd0);
    @(posedge clk);
    #1;
    check("ready_after_release", 32'(pif.plot_ready), 32'd1);
  endtask

  initial begin
    int done_before;
    bit hit;
    reset = 1'b0; clear = 1'b0;
    pif.plot = 1'b0; pif.x = '0; pif.y = '0; pif.colour = '0;
    #2;
    apply_reset();

    // Single plot latency: written after the second edge following acceptance
    drive_cycle(1'b1, 10, 5, 4, 1'b0);
    idle_in();
    @(negedge clk); check("lat_n0_we", 32'(mem_we), 32'd0);
    @(negedge clk); check("lat_n1_we", 32'(mem_we), 32'd0);
    @(negedge clk); check("lat_n2_we", 32'(mem_we), 32'd1);
    check("lat_n2_addr", 32'(mem_addr), 32'd810);
    check("lat_n2_data", 32'(mem_data), 32'd4);
    @(negedge clk); check("lat_n3_we", 32'(mem_we), 32'd0);
    wait_idle("single");

    // Screen corners back-to-back
    drive_cycle(1'b1, 0, 0, 7, 1'b0);
    drive_cycle(1'b1, 159, 119, 1, 1'b0);
    idle_in();
    wait_idle("corners");

    // Clipping boundaries, then saturation
    drive_cycle(1'b1, 160, 0, 2, 1'b0);
    drive_cycle(1'b1, 0, 120, 2, 1'b0);
    idle_in();
    wait_idle("clip");
    check("drop_two", 32'(drop_count), 32'd2);
    for (int i = 0; i < 300; i++)
      drive_cycle(1'b1, $urandom_range(160, 255), $urandom_range(0, 127), $urandom_range(0, 7), 1'b0);
    idle_in();
    wait_idle("clip_sat");
    check("drop_saturated", 32'(drop_count), 32'd255);

    // Randomised traffic after a reset clears the drop counter
    apply_reset();
    for (int i = 0; i < 300; i++)
      drive_cycle(($urandom_range(0, 3) != 0), $urandom_range(0, 175), $urandom_range(0, 127),
                  $urandom_range(0, 7), 1'b0);
    idle_in();
    wait_idle("random");
    check("drop_random", 32'(drop_count), 32'(exp_drop));

    // Clear with three plots queued ahead of it; plots attempted meanwhile are refused
    drive_cycle(1'b1, $urandom_range(0, 159), $urandom_range(0, 119), $urandom_range(0, 7), 1'b0);
    drive_cycle(1'b1, $urandom_range(0, 159), $urandom_range(0, 119), $urandom_range(0, 7), 1'b0);
    drive_cycle(1'b1, $urandom_range(0, 159), $urandom_range(0, 119), $urandom_range(0, 7), 1'b1);
    for (int i = 0; i < 40; i++)
      drive_cycle(1'b1, $urandom_range(0, 255), $urandom_range(0, 127), $urandom_range(0, 7),
                  ($urandom_range(0, 1) == 1));
    idle_in();
    wait_idle("clear");
    check("clear_done_once", 32'(clears_done), 32'd1);
    check("drop_unchanged", 32'(drop_count), 32'(exp_drop));

    // Reset in the middle of a clear
    drive_cycle(1'b1, 3, 3, 6, 1'b1);
    idle_in();
    hit = 1'b0;
    for (int i = 0; i < 25000 && !hit; i++) begin
      @(negedge clk);
      #2;
      hit = (mem_we === 1'b1) && (mem_addr == 15'd5000) && (clears_issued != clears_done);
    end
    check("reached_addr_5000", 32'(hit), 32'd1);
    done_before = clears_done;
    apply_reset();
    repeat (5) @(negedge clk);
    check("no_done_after_reset", 32'(clears_done), 32'(done_before));
    drive_cycle(1'b1, 1, 1, 5, 1'b0);
    idle_in();
    wait_idle("post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
